// File: rtl/reshaper_pkg.sv
// Shared types for the reshaper and its job scheduler: descriptor layout and
// scheduler state encoding.
package reshaper_pkg;

  localparam int unsigned AW   = 16;
  localparam int unsigned ADIM = 6;

  typedef struct packed {
    logic [AW-1:0]            rreq_num;
    logic [AW-1:0]            raddr_base;
    logic [ADIM-1:0][AW-1:0]  raddr_size;
    logic [ADIM-1:0][AW-1:0]  raddr_stride;
    logic [AW-1:0]            wreq_num;
    logic [AW-1:0]            waddr_base;
    logic [ADIM-1:0][AW-1:0]  waddr_size;
    logic [ADIM-1:0][AW-1:0]  waddr_stride;
    logic [AW-1:0]            rdata_size;
    logic [AW-1:0]            wdata_size;
  } reshape_desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DONE,
    S_HALT
  } sched_state_e;

endpackage

// File: rtl/reshaper_cmd_fifo.sv
// Synchronous FIFO holding queued reshape commands; head is read combinationally.
module reshaper_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/reshaper_job_sched.sv
// Queues reshape descriptors and launches them one at a time on the reshaper,
// reporting per-job completion and flagging hung jobs with a watchdog.
module reshaper_job_sched
  import reshaper_pkg::*;
#(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned TW     = 20,
  parameter int unsigned TAGW   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_vld,
  output logic                      cmd_rdy,
  input  reshape_desc_t             cmd_desc,
  input  logic [TAGW-1:0]           cmd_tag,
  output reshape_desc_t             cfg,
  output logic                      init_pulse,
  input  logic                      finish,
  input  logic [TW-1:0]             tmo_limit,
  input  logic                      clear_err,
  output logic                      done_vld,
  output logic [TAGW-1:0]           done_tag,
  output logic                      done_err,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   q_cnt
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned FW = $bits(reshape_desc_t) + TAGW;

  sched_state_e  state;
  sched_state_e  next_state;
  logic          push;
  logic          pop;
  logic          q_full;
  logic          q_empty;
  logic [FW-1:0] q_head;
  reshape_desc_t head_desc;
  logic [TAGW-1:0] head_tag;
  logic [TAGW-1:0] active_tag;
  logic [TW-1:0] timer;
  logic [CW-1:0] cnt_nxt;
  logic          timeout;
  logic          report;

  assign cmd_rdy = ~q_full;
  assign push    = cmd_vld & cmd_rdy;
  assign {head_tag, head_desc} = q_head;
  assign timeout = (tmo_limit != '0) && (timer == tmo_limit);

  reshaper_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (QDEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({cmd_tag, cmd_desc}),
    .pop     (pop),
    .rdata   (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_cnt)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          pop        = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_LOAD:  next_state = S_START;
      S_START: next_state = S_RUN;
      // finish takes priority over a coincident watchdog expiry
      S_RUN: begin
        if (finish)       next_state = S_DONE;
        else if (timeout) next_state = S_HALT;
      end
      S_DONE:  next_state = S_IDLE;
      S_HALT: begin
        if (clear_err) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase

    cnt_nxt = q_cnt;
    if (push && !pop)      cnt_nxt = q_cnt + 1'b1;
    else if (!push && pop) cnt_nxt = q_cnt - 1'b1;

    report = (next_state == S_DONE) || ((next_state == S_HALT) && (state != S_HALT));
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cfg        <= '0;
      active_tag <= '0;
      timer      <= '0;
      init_pulse <= 1'b0;
      done_vld   <= 1'b0;
      done_err   <= 1'b0;
      done_tag   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      init_pulse <= (next_state == S_START);
      done_vld   <= report;
      done_err   <= (next_state == S_HALT);
      busy       <= (next_state != S_IDLE) || (cnt_nxt != '0);
      if (pop) begin
        cfg        <= head_desc;
        active_tag <= head_tag;
      end
      if (report) done_tag <= active_tag;
      if (state == S_START)                 timer <= '0;
      else if (state == S_RUN && timer != '1) timer <= timer + 1'b1;
    end
  end

endmodule

// File: doc/reshaper_job_sched.md
# reshaper_job_sched

Job scheduler in front of `reshaper`. It queues reshape descriptors from the host/sequencer and launches them one at a time: it drives the reshaper's configuration inputs and `init_pulse`, then waits for `finish`. It reports per-job completion with a tag, and a watchdog flags hung jobs. It sits between the command bus and the `reshaper` configuration and control ports; the memory data paths are untouched.

## Interface
Parameters:
- QDEPTH, 4, descriptor queue depth; power of two, at least 2
- TW, 20, watchdog timer width
- TAGW, 4, job tag width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_vld  in  1  descriptor valid
- cmd_rdy  out  1  queue can accept; registered, equals !full
- cmd_desc  in  reshape_desc_t  descriptor: rreq_num, raddr_base, raddr_size[ADIM], raddr_stride[ADIM], wreq_num, waddr_base, waddr_size[ADIM], waddr_stride[ADIM], rdata_size, wdata_size
- cmd_tag  in  TAGW  job tag
- cfg  out  reshape_desc_t  active descriptor fanned out to the reshaper config ports
- init_pulse  out  1  reshaper start, one-cycle pulse
- finish  in  1  reshaper job complete
- tmo_limit  in  TW  watchdog limit in cycles; 0 disables the watchdog
- clear_err  in  1  leaves HALT
- done_vld  out  1  one-cycle completion pulse, no backpressure
- done_tag  out  TAGW  tag of the completed job
- done_err  out  1  completion was a timeout
- busy  out  1  state != IDLE or queue non-empty
- q_cnt  out  $clog2(QDEPTH)+1  queue occupancy

## Operation
- Queue: a push occurs when cmd_vld && cmd_rdy; FIFO order; a push into an empty queue is visible the next cycle.
- cmd_rdy is computed from the registered occupancy. When full, it stays low even if a pop occurs in the same cycle.
- FSM states are IDLE, LOAD, START, RUN, DONE, HALT.
- IDLE:
  - if the queue is non-empty, pop the head into the active registers (cfg, active tag) and go to LOAD;
  - otherwise stay in IDLE.
- LOAD: cfg is stable for one cycle before start (setup for the reshaper); go to START.
- START: init_pulse=1 for exactly this cycle; clear the timer; go to RUN.
- RUN:
  - the timer increments each cycle, saturating at all-ones;
  - finish=1 → DONE;
  - else if tmo_limit!=0 and timer==tmo_limit → HALT, with done_vld=1 and done_err=1 in that transition cycle's successor.
- DONE: done_vld=1, done_err=0, done_tag=active tag; go to IDLE.
- HALT:
  - done_vld pulses once on entry;
  - the sticky err flag is set, and done_err holds 1 while in HALT;
  - no new job launches;
  - clear_err → IDLE.
  - The queue still accepts pushes while in HALT.
- Ignored events:
  - finish outside RUN is ignored; this includes finish during LOAD or START.
  - clear_err outside HALT is ignored.
- Simultaneous events:
  - finish and timeout in the same cycle: finish wins, and the job goes to DONE with no error.
  - A push and a pop in the same cycle with the queue non-full: occupancy is unchanged.
- cfg holds its value after the job completes, until the next pop.

## Timing
- Reset values:
  - state=IDLE, queue empty, q_cnt=0, cmd_rdy=1;
  - init_pulse=0, done_vld=0, done_err=0, done_tag=0;
  - cfg all zero, busy=0, timer=0.
- Latency:
  - push at cycle t into an idle, empty scheduler → pop at t+1, LOAD at t+2, init_pulse at t+3;
  - finish at cycle f → done_vld at f+1;
  - the next queued job's init_pulse is at f+4.
- All outputs are registered.
- Reset mid-job: the queue and the active job are discarded, and no done_vld is issued.

## Structure
- Package `reshaper_pkg`:
  - AW=16, ADIM=6;
  - reshape_desc_t (packed struct);
  - sched_state_e enum.
- The top-level and the reshaper import it.
- One sub-module, `reshaper_cmd_fifo`: a synchronous FIFO parameterised by width and depth, with full/empty/count outputs.
- The FSM, timer and active registers live in the top-level.

## Test plan
- Single job, tag 3, raddr_base=0x100: push at t → init_pulse at t+3 with cfg.raddr_base=0x100; finish 50 cycles later → done_vld=1, done_tag=3, done_err=0 the next cycle.
- Push 5 jobs back-to-back with QDEPTH=4 and the reshaper idle: cmd_rdy drops after the queue is full. Jobs complete in order with tags 0-4, and init_pulses are spaced finish+4 apart.
- Watchdog, tmo_limit=10, finish never asserted: done_vld=1 with done_err=1 arrives about 11 cycles after init_pulse. The FSM stays in HALT with queued jobs held; clear_err → next init_pulse 3 cycles later.
- finish coincident with the timer reaching tmo_limit → done_err=0, and the FSM does not enter HALT.
- Stray finish during IDLE and LOAD → no done_vld, and the FSM is not advanced.
- reset_n asserted during RUN with 2 jobs queued → all outputs at reset values immediately, q_cnt=0, and no done_vld after release.
